// File: rtl/div_mon_pkg.sv
// Shared types and default parameters for the divided-clock edge/period monitor.
package div_mon_pkg;

  localparam int DIV_MON_NCH      = 3;
  localparam int DIV_MON_PERIOD_W = 4;
  localparam int DIV_MON_LOCK_CNT = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } div_mon_state_e;

endpackage

// File: rtl/div_mon_chan.sv
// One monitored divider channel: edge strobes, period counter, lock FSM and sticky error.
module div_mon_chan
  import div_mon_pkg::*;
#(
  parameter int PERIOD_W = DIV_MON_PERIOD_W,
  parameter int LOCK_CNT = DIV_MON_LOCK_CNT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                div_i,
  input  logic [PERIOD_W-1:0] exp_period_i,
  input  logic                err_clr_i,
  output logic                rise_o,
  output logic                fall_o,
  output logic                lock_o,
  output logic                err_o,
  output logic [PERIOD_W-1:0] last_period_o
);

  localparam logic [PERIOD_W-1:0] CNT_MAX  = {PERIOD_W{1'b1}};
  localparam logic [PERIOD_W:0]   ONE_W    = {{PERIOD_W{1'b0}}, 1'b1};
  localparam logic [2:0]          GOOD_MAX = 3'(LOCK_CNT);

  div_mon_state_e      state_q, state_d;
  logic                prev_q;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [2:0]          good_q, good_d;
  logic [PERIOD_W-1:0] last_q, last_d;
  logic                rise_q, fall_q, lock_q, err_q;
  logic                lock_d, err_d;
  logic                rise_s, fall_s, err_set_s;
  logic [PERIOD_W:0]   meas_w_s;
  logic [PERIOD_W-1:0] meas_s;

  // Next-state logic for edge detect, counter, FSM and sticky error
  always_comb begin
    rise_s    = div_i & ~prev_q;
    fall_s    = ~div_i & prev_q;
    state_d   = state_q;
    good_d    = good_q;
    last_d    = last_q;
    err_set_s = 1'b0;

    if (rise_s) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + ONE_W[PERIOD_W-1:0];
    end else begin
      cnt_d = cnt_q;
    end

    // Period is counted rise-to-rise; the extra bit catches the saturated case.
    meas_w_s = {1'b0, cnt_q} + ONE_W;
    if (meas_w_s[PERIOD_W]) begin
      meas_s = CNT_MAX;
    end else begin
      meas_s = meas_w_s[PERIOD_W-1:0];
    end

    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d = ARMED;
          good_d  = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED, LOCKED: begin
        if (rise_s) begin
          last_d = meas_s;
          if (meas_s == exp_period_i) begin
            if (good_q == GOOD_MAX) begin
              good_d = good_q;
            end else begin
              good_d = good_q + 3'd1;
            end
            if (good_d == GOOD_MAX) begin
              state_d = LOCKED;
            end else begin
              state_d = state_q;
            end
          end else begin
            good_d    = 3'd0;
            state_d   = ARMED;
            err_set_s = 1'b1;
          end
        end else if (cnt_q == CNT_MAX) begin
          good_d    = 3'd0;
          state_d   = IDLE;
          err_set_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        good_d  = 3'd0;
      end
    endcase

    // A new error outranks a simultaneous clear.
    if (err_set_s) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    lock_d = (state_d == LOCKED);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      good_q  <= 3'd0;
      last_q  <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= div_i;
      cnt_q   <= cnt_d;
      good_q  <= good_d;
      last_q  <= last_d;
      rise_q  <= rise_s;
      fall_q  <= fall_s;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end

  assign rise_o        = rise_q;
  assign fall_o        = fall_q;
  assign lock_o        = lock_q;
  assign err_o         = err_q;
  assign last_period_o = last_q;

endmodule

// File: rtl/div_edge_monitor.sv
// Edge detector and period checker for NCH divided clocks; one channel instance per bit.
module div_edge_monitor
  import div_mon_pkg::*;
#(
  parameter int NCH      = DIV_MON_NCH,
  parameter int PERIOD_W = DIV_MON_PERIOD_W,
  parameter int LOCK_CNT = DIV_MON_LOCK_CNT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          div_in,
  input  logic [NCH*PERIOD_W-1:0] exp_period,
  input  logic                    err_clr,
  output logic [NCH-1:0]          rise,
  output logic [NCH-1:0]          fall,
  output logic [NCH-1:0]          lock,
  output logic [NCH-1:0]          err,
  output logic [NCH*PERIOD_W-1:0] last_period
);

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    div_mon_chan #(
      .PERIOD_W(PERIOD_W),
      .LOCK_CNT(LOCK_CNT)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .div_i        (div_in[g]),
      .exp_period_i (exp_period[g*PERIOD_W +: PERIOD_W]),
      .err_clr_i    (err_clr),
      .rise_o       (rise[g]),
      .fall_o       (fall[g]),
      .lock_o       (lock[g]),
      .err_o        (err[g]),
      .last_period_o(last_period[g*PERIOD_W +: PERIOD_W])
    );
  end

endmodule

// File: tb/tb_div_edge_monitor.sv
// Scoreboard bench: drivers queue hand-computed status per rise, a monitor checks strobes.
module tb_div_edge_monitor;

  localparam int NCH = 3;
  localparam int PW  = 4;

  typedef struct {
    int lock;
    int err;
    int last;
    int hi;
  } exp_t;

  logic              clk;
  logic              reset;
  logic [NCH-1:0]    div_r;
  logic [NCH*PW-1:0] exp_period;
  logic              err_clr;
  logic [NCH-1:0]    rise, fall, lock, err;
  logic [NCH*PW-1:0] last_period;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sbq[NCH][$];

  logic [NCH-1:0] prev_rise = '0;
  logic [NCH-1:0] prev_fall = '0;
  logic [NCH-1:0] fall_pend = '0;
  int             rise_cyc[NCH];
  int             exp_hi[NCH];

  div_edge_monitor #(.NCH(NCH), .PERIOD_W(PW), .LOCK_CNT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .div_in     (div_r),
    .exp_period (exp_period),
    .err_clr    (err_clr),
    .rise       (rise),
    .fall       (fall),
    .lock       (lock),
    .err        (err),
    .last_period(last_period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // One divider period on channel ch; queues what the DUT must show with this rise.
  task automatic drive(input int ch, input int hi, input int lo,
                       input int el, input int ee, input int elast);
    exp_t e;
    e.lock = el; e.err = ee; e.last = elast; e.hi = hi;
    div_r[ch] = 1'b1;
    sbq[ch].push_back(e);
    repeat (hi) @(negedge clk);
    div_r[ch] = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rise", int'(rise), 0);
    chk("rst_fall", int'(fall), 0);
    chk("rst_lock", int'(lock), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_last_period", int'(last_period), 0);
    reset = 1'b0;
  endtask

  // Monitor: every rise pops one expectation; every fall is checked against its rise.
  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rise[i]) begin
        chk($sformatf("rise_width_ch%0d", i), int'(prev_rise[i]), 0);
        if (sbq[i].size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rise_unexpected_ch%0d: got rise, expected none (cycle %0d)", i, cyc);
        end else begin
          exp_t e;
          e = sbq[i].pop_front();
          chk($sformatf("lock_ch%0d", i), int'(lock[i]), e.lock);
          chk($sformatf("err_ch%0d", i), int'(err[i]), e.err);
          chk($sformatf("last_period_ch%0d", i), int'(last_period[i*PW +: PW]), e.last);
          rise_cyc[i]  = cyc;
          exp_hi[i]    = e.hi;
          fall_pend[i] = 1'b1;
        end
      end
      if (fall[i]) begin
        chk($sformatf("fall_width_ch%0d", i), int'(prev_fall[i]), 0);
        if (fall_pend[i]) begin
          chk($sformatf("fall_spacing_ch%0d", i), cyc - rise_cyc[i], exp_hi[i]);
        end else begin
          n_tests++;
          n_fail++;
          $display("FAIL fall_unexpected_ch%0d: got fall, expected none (cycle %0d)", i, cyc);
        end
        fall_pend[i] = 1'b0;
      end
    end
    prev_rise = rise;
    prev_fall = fall;
  end

  initial begin
    repeat (3000) @(posedge clk);
    $display("FAIL watchdog: got no finish, expected finish within 3000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    div_r      = '0;
    err_clr    = 1'b0;
    exp_period = {4'd6, 4'd4, 4'd2};
    do_reset();

    // Free-running lock-up on all channels; equal 24-cycle spans avoid idle gaps.
    fork
      for (int k = 0; k < 12; k++) drive(0, 1, 1, (k >= 2) ? 1 : 0, 0, (k == 0) ? 0 : 2);
      for (int k = 0; k < 6; k++)  drive(1, 2, 2, (k >= 2) ? 1 : 0, 0, (k == 0) ? 0 : 4);
      for (int k = 0; k < 4; k++)  drive(2, 3, 3, (k >= 2) ? 1 : 0, 0, (k == 0) ? 0 : 6);
    join
    chk("locked_all", int'(lock), 7);
    do_reset();

    // Timeout on ch0, stretched period on ch2, undisturbed ch1.
    fork
      begin
        exp_t e;
        for (int k = 0; k < 4; k++) drive(0, 1, 1, (k >= 2) ? 1 : 0, 0, (k == 0) ? 0 : 2);
        e.lock = 1; e.err = 0; e.last = 2; e.hi = 1;
        div_r[0] = 1'b1;
        sbq[0].push_back(e);
        @(negedge clk);
        div_r[0] = 1'b0;
        repeat (15) @(negedge clk);
        chk("pre_timeout_err0", int'(err[0]), 0);
        chk("pre_timeout_lock0", int'(lock[0]), 1);
        @(negedge clk);
        chk("timeout_err0", int'(err[0]), 1);
        chk("timeout_lock0", int'(lock[0]), 0);
        chk("timeout_last0", int'(last_period[PW-1:0]), 2);
        drive(0, 1, 1, 0, 1, 2);
        drive(0, 1, 1, 0, 1, 2);
        for (int k = 0; k < 6; k++) drive(0, 1, 1, 1, 1, 2);
      end
      for (int k = 0; k < 10; k++) drive(1, 2, 2, (k >= 2) ? 1 : 0, 0, (k == 0) ? 0 : 4);
      begin
        drive(2, 3, 3, 0, 0, 0);
        drive(2, 3, 3, 0, 0, 6);
        drive(2, 3, 3, 1, 0, 6);
        drive(2, 4, 3, 1, 0, 6);
        drive(2, 3, 3, 0, 1, 7);
        drive(2, 3, 3, 0, 1, 6);
        drive(2, 3, 3, 1, 1, 6);
      end
    join
    do_reset();

    // ch1 alone: mismatch coinciding with err_clr, then err_clr by itself.
    begin
      exp_t e;
      drive(1, 2, 2, 0, 0, 0);
      drive(1, 2, 2, 0, 0, 4);
      drive(1, 2, 2, 1, 0, 4);
      drive(1, 3, 2, 1, 0, 4);
      e.lock = 0; e.err = 1; e.last = 5; e.hi = 2;
      div_r[1] = 1'b1;
      err_clr  = 1'b1;
      sbq[1].push_back(e);
      @(negedge clk);
      err_clr = 1'b0;
      @(negedge clk);
      chk("err_held1", int'(err[1]), 1);
      div_r[1] = 1'b0;
      err_clr  = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_clr_alone1", int'(err[1]), 0);
      @(negedge clk);
      drive(1, 2, 2, 0, 0, 4);
      drive(1, 2, 2, 1, 0, 4);
    end
    repeat (2) @(negedge clk);
    chk("final_lock", int'(lock), 2);
    chk("final_err", int'(err), 0);
    for (int i = 0; i < NCH; i++) chk($sformatf("sb_drained_ch%0d", i), sbq[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_edge_monitor.md
# div_edge_monitor

Per-channel edge detector and period checker placed directly downstream of the clock divider. It samples NCH divided-clock levels (e.g. div2/div4/div6) in the source clock domain and produces single-cycle rise/fall strobes usable as clock enables. It also measures each channel's period, compares it against a programmed expected value, and reports lock and sticky error status. Downstream logic gates on `lock` before trusting the strobes.

## Interface
- `NCH`, 3: number of monitored divider channels.
- `PERIOD_W`, 4: width of period counter and expected/measured period fields.
- `LOCK_CNT`, 2: consecutive good periods required to assert lock (1..7).
- `clk`  in  1  source clock; the same clock drives the divider. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `div_in`  in  NCH  divided-clock levels, synchronous to `clk`.
- `exp_period`  in  NCH*PERIOD_W  expected period in `clk` cycles per channel, channel i at bits [i*PERIOD_W +: PERIOD_W]. Quasi-static; legal range 2..2^PERIOD_W-2.
- `err_clr`  in  1  clears all sticky errors.
- `rise`  out  NCH  one-cycle strobe per rising edge.
- `fall`  out  NCH  one-cycle strobe per falling edge.
- `lock`  out  NCH  channel period verified.
- `err`  out  NCH  sticky period error.
- `last_period`  out  NCH*PERIOD_W  most recent measured period.

## Operation
- Per channel: `prev` holds the previous `div_in` sample. An edge is a rise when `div_in=1, prev=0`, and a fall when `div_in=0, prev=1`.
- Counter `cnt` (PERIOD_W bits):
  - Cleared to 0 in a rise cycle.
  - Otherwise increments each cycle, saturating at 2^PERIOD_W-1.
- Per-channel state machine, states IDLE, ARMED, LOCKED:
  - IDLE: the first rise moves to ARMED. No comparison is made; `good` is set to 0.
  - ARMED/LOCKED, on rise: measured = cnt+1, computed at PERIOD_W+1 bits and clipped to 2^PERIOD_W-1. Measured is written to `last_period`.
  - Match (measured == exp_period): `good` increments, saturating at LOCK_CNT. Reaching LOCK_CNT moves ARMED to LOCKED.
  - Mismatch: `good` is cleared, the state returns to ARMED, and `err` is set.
  - Timeout: `cnt` at saturation with no rise. `err` is set and the state goes to IDLE, which also clears `lock`. `last_period` is held.
- `lock` = (state == LOCKED).
- Clearing `err`: `err_clr` clears every `err` bit. If a new error and `err_clr` occur in the same cycle, the error wins and the bit stays 1.
- A change to `exp_period` takes effect at the next comparison. Lock is not dropped until a mismatch occurs.
- Reset mid-operation: all state returns to reset values on the next edge. `prev` resets to 0, so a channel that is high right after reset produces a rise. That rise only arms the channel.

## Timing
- All outputs are registered.
- Reset values: `rise`=0, `fall`=0, `lock`=0, `err`=0, `last_period`=0, state=IDLE, `cnt`=0, `good`=0, `prev`=0.
- Latency:
  - `rise`/`fall` assert the cycle after the cycle in which the edge condition holds on `div_in`/`prev`, for exactly one cycle.
  - `last_period`, `lock` and `err` update in that same cycle as the corresponding `rise`.
  - Timeout `err` asserts the cycle after `cnt` reaches saturation.
- Channels are fully independent: no cross-channel interaction except the shared `err_clr`.

## Structure
- Package `div_mon_pkg` holds:
  - the state enum `div_mon_state_e` (IDLE, ARMED, LOCKED);
  - default constants `DIV_MON_NCH`, `DIV_MON_PERIOD_W`, `DIV_MON_LOCK_CNT`.
- Sub-module `div_mon_chan` implements one channel (edge detect, counter, FSM, err).
- The top generates NCH instances and handles slicing of the packed buses.

## Test plan
- Reset, then drive the divider patterns, exp_period = {6,4,2}:
  - first rise per channel (1 cycle after div_in goes high): `lock`=0;
  - `lock` = 1 on channel 0 after its 3rd rise, channel 1 after its 3rd rise, channel 2 after its 3rd rise;
  - `last_period` = {6,4,2};
  - `err` = 0 throughout.
- `rise`/`fall` on channel 1 (period 4, high 2): exactly one strobe per edge, rise and fall spaced 2 cycles apart, each 1 cycle wide.
- With channel 2 locked, stretch one high phase by 1 cycle (period 7):
  - `err[2]`=1 and `lock[2]`=0 with that rise, `last_period`=7;
  - relock after 2 further good periods.
- Hold channel 0 low for 16 cycles with PERIOD_W=4: `err[0]`=1 and `lock[0]`=0 when `cnt` saturates; the next rise only re-arms.
- `err_clr` in the same cycle as a new mismatch: `err` stays 1. `err_clr` alone: `err`=0 the next cycle.
- Assert `reset` mid-stream for 1 cycle: all outputs are 0 the next cycle, and lock re-acquires after LOCK_CNT+1 rises.
